// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment scanner: NUM_DIGITS hex digits from one packed value,
// with frame-synchronous double buffering, leading-zero blanking and anti-ghost blanking.
module seg7_scan_display #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Load,
    input  logic [NUM_DIGITS-1:0]   DpIn,
    input  logic                    LzBlank,
    output logic [6:0]              out7,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   en_out,
    output logic                    FrameDone
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic OFF = (ACTIVE_LOW != 0);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          tick;
    logic          frame_tick;
    logic          in_blank;

    logic [4*NUM_DIGITS-1:0] stage_val;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_run;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] en_sel;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] en_n;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    assign tick       = (presc == PRESC_MAX);
    assign frame_tick = tick && (idx == IDX_MAX);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (presc < PW'(BLANK_CYCLES));
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Load is a single-cycle strobe with no back-pressure: Value/DpIn are taken
    // whenever Load=1. The display copy only moves at a frame boundary, so a
    // frame is never torn; a Load on that boundary cycle bypasses staging.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stage_val <= '0;
            stage_dp  <= '0;
            pending   <= 1'b0;
            disp_val  <= '0;
            disp_dp   <= '0;
        end else if (frame_tick && Load) begin
            disp_val  <= Value;
            disp_dp   <= DpIn;
            stage_val <= Value;
            stage_dp  <= DpIn;
            pending   <= 1'b0;
        end else if (Load) begin
            stage_val <= Value;
            stage_dp  <= DpIn;
            pending   <= 1'b1;
        end else if (frame_tick && pending) begin
            disp_val <= stage_val;
            disp_dp  <= stage_dp;
            pending  <= 1'b0;
        end
    end

    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && (disp_val[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run && (i != 0);
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        en_sel  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = disp_val[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_lz    = lz_mask[i];
                en_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_n = hex_glyph(cur_nib);
        dp_n  = cur_dp;
        en_n  = en_sel;
        if (in_blank) begin
            seg_n = '0;
            dp_n  = 1'b0;
            en_n  = '0;
        end else if (LzBlank && cur_lz) begin
            seg_n = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out7      <= {7{OFF}};
            dp_out    <= OFF;
            en_out    <= {NUM_DIGITS{OFF}};
            FrameDone <= 1'b0;
        end else begin
            out7      <= seg_n ^ {7{OFF}};
            dp_out    <= dp_n ^ OFF;
            en_out    <= en_n ^ {NUM_DIGITS{OFF}};
            FrameDone <= frame_tick;
        end
    end

endmodule
